mux_n_to_1_stream: RTL and testbench
====================================

MUX_N_TO_1_STREAM -- requirements
Module: mux_n_to_1_stream

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, width of each data channel.
REQ-002 SHALL have parameter NUM_INPUTS, default 8, number of input channels (legal range 2..64).
REQ-003 SHALL have parameter SEL_WIDTH, default 3, select/index width (ceil(log2(NUM_INPUTS))).
REQ-004 SHALL have port i_clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_A  input  NUM_INPUTS*BIT_WIDTH  flattened channel data; channel k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-007 SHALL have port i_valid  input  NUM_INPUTS  per-channel valid.
REQ-008 SHALL have port o_ready  output  NUM_INPUTS  per-channel accept strobe.
REQ-009 SHALL have port i_mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port i_sel  input  SEL_WIDTH  channel index used in fixed mode.
REQ-011 SHALL have port o_B  output  BIT_WIDTH  registered selected data.
REQ-012 SHALL have port o_valid  output  1  o_B holds an unconsumed word.
REQ-013 SHALL have port i_ready  input  1  downstream accepts o_B.
REQ-014 SHALL have port o_src  output  SEL_WIDTH  index of the channel that produced o_B.

Function
REQ-015 SHALL hold a one-entry output register; slot free = (!o_valid || i_ready).
REQ-016 Fixed mode: grant channel i_sel iff slot free, i_valid[i_sel]=1 and i_sel < NUM_INPUTS; i_sel >= NUM_INPUTS grants nothing.
REQ-017 Round-robin mode: grant the first channel with i_valid=1 searching ptr+1, ptr+2, ... wrapping at NUM_INPUTS-1 to 0, ptr itself last; grant only if slot free.
REQ-018 o_ready SHALL be combinational, one-hot on the granted channel, all-zero when no grant; at most one bit set per cycle.
REQ-019 On grant: next edge loads o_B with granted data, o_src with granted index, o_valid=1; latency one cycle from accept to o_valid.
REQ-020 No grant and i_ready=1: o_valid clears next edge; o_B and o_src hold their values.
REQ-021 Simultaneous drain and grant (o_valid=1, i_ready=1, grant) SHALL replace the word with no bubble; full throughput of one word per cycle.
REQ-022 o_valid=1 and i_ready=0: o_B, o_src, o_valid SHALL hold; o_ready all-zero.
REQ-023 ptr SHALL update to the granted index on every round-robin grant; it holds otherwise and does not move in fixed mode.
REQ-024 i_mode and i_sel changes take effect in the same cycle and never disturb a word already in the output register.

Reset
REQ-025 i_rst_n low SHALL asynchronously force o_valid=0, o_B=0, o_src=0, ptr=NUM_INPUTS-1 (channel 0 first priority).
REQ-026 o_ready SHALL be all-zero while i_rst_n is low; a word held mid-transfer at reset is discarded.
REQ-027 Reset release SHALL be synchronous to i_clk; first grant possible on the first edge after release.

Configuration
REQ-028 Macro MUX_STREAM_RR_EN defined: round-robin logic and ptr present, i_mode honoured per REQ-017.
REQ-029 MUX_STREAM_RR_EN undefined: no ptr, no arbiter; i_mode ignored, block always operates in fixed mode; port list unchanged.

Verification
REQ-030 Fixed mode, i_sel=3, i_valid=8'hFF, ch3=16'h00A3, i_ready=1 -> o_ready=8'h08, next cycle o_B=16'h00A3, o_src=3, o_valid=1.
REQ-031 Round-robin after reset, i_valid=8'hFF held 10 cycles, i_ready=1 -> o_src sequence 0,1,...,7,0,1 with no gap in o_valid.
REQ-032 Round-robin, i_valid=8'b1000_0010, ptr=7 -> grant ch1, then ch7, then ch1 (wrap).
REQ-033 o_valid=1 and i_ready=0 for 5 cycles with valid inputs -> o_ready=0, o_B unchanged; i_ready=1 -> new word next cycle.
REQ-034 Fixed mode i_sel=7 with NUM_INPUTS=6 -> o_ready=0, o_valid stays 0.
REQ-035 i_rst_n low mid-stream with o_valid=1 -> o_valid=0, o_B=0 immediately without clock edge; after release round-robin restarts at ch0.

Source files
------------

// File: rtl/mux_n_to_1_stream.sv
// N-to-1 stream multiplexer with a one-entry registered output stage.
// Define MUX_STREAM_RR_EN to enable the round-robin arbiter (i_mode=1); otherwise fixed select only.
module mux_n_to_1_stream #(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_A,
    input  logic [NUM_INPUTS-1:0]           i_valid,
    output logic [NUM_INPUTS-1:0]           o_ready,
    input  logic                            i_mode,
    input  logic [SEL_WIDTH-1:0]            i_sel,
    output logic [BIT_WIDTH-1:0]            o_B,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [SEL_WIDTH-1:0]            o_src
);

    logic [BIT_WIDTH-1:0]  chan_data [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] fixed_req;

    logic                  valid_reg, valid_next;
    logic [BIT_WIDTH-1:0]  b_reg, b_next;
    logic [SEL_WIDTH-1:0]  src_reg, src_next;

    logic                  slot_free;
    logic                  grant_any;
    logic [SEL_WIDTH-1:0]  grant_idx;

    logic                  rr_mode;
    logic                  rr_any;
    logic [SEL_WIDTH-1:0]  rr_idx;

    // Per-channel compare against i_sel means an out-of-range select simply matches nothing.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
            assign chan_data[gi] = i_A[gi*BIT_WIDTH +: BIT_WIDTH];
            assign fixed_req[gi] = i_valid[gi] && (i_sel == SEL_WIDTH'(gi));
        end
    endgenerate

    assign slot_free = !valid_reg || i_ready;

`ifdef MUX_STREAM_RR_EN
    localparam logic [SEL_WIDTH:0] NUM_IN_W = (SEL_WIDTH+1)'(NUM_INPUTS);

    logic [SEL_WIDTH-1:0] ptr_reg;

    assign rr_mode = i_mode;

    // Search ptr+1 upward with wrap; ptr itself is visited last.
    always_comb begin
        logic [SEL_WIDTH:0] cand;
        rr_any = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = {1'b0, ptr_reg} + (SEL_WIDTH+1)'(k);
            if (cand >= NUM_IN_W) begin
                cand = cand - NUM_IN_W;
            end
            if (!rr_any && i_valid[cand[SEL_WIDTH-1:0]]) begin
                rr_any = 1'b1;
                rr_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg <= SEL_WIDTH'(NUM_INPUTS - 1);
        end else if (rr_mode && grant_any) begin
            ptr_reg <= rr_idx;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign rr_mode     = 1'b0;
    assign rr_any      = 1'b0;
    assign rr_idx      = '0;
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_idx = i_sel;
        if (rr_mode) begin
            grant_any = rr_any;
            grant_idx = rr_idx;
        end else begin
            grant_any = |fixed_req;
        end
        grant_any = grant_any && slot_free && i_rst_n;
    end

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
            assign o_ready[gi] = grant_any && (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    // A grant always wins over draining so back-to-back words never bubble.
    always_comb begin
        valid_next = valid_reg;
        b_next     = b_reg;
        src_next   = src_reg;
        if (grant_any) begin
            valid_next = 1'b1;
            b_next     = chan_data[grant_idx];
            src_next   = grant_idx;
        end else if (i_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg <= 1'b0;
            b_reg     <= '0;
            src_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            b_reg     <= b_next;
            src_reg   <= src_next;
        end
    end

    assign o_valid = valid_reg;
    assign o_B     = b_reg;
    assign o_src   = src_reg;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Scoreboard bench for mux_n_to_1_stream: queue-based reference model plus a decoupled output monitor.
// Round-robin scenarios run only when MUX_STREAM_RR_EN is defined.
module tb_mux_n_to_1_stream;

    localparam int BW = 16;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int N6 = 6;
`ifdef MUX_STREAM_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*BW-1:0] a;
    logic [N-1:0]    valid;
    logic [N-1:0]    o_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [BW-1:0]   o_b;
    logic            o_valid;
    logic            ready;
    logic [SW-1:0]   o_src;

    logic [N6*BW-1:0] a6;
    logic [N6-1:0]    valid6;
    logic [N6-1:0]    o_ready6;
    logic             mode6;
    logic [SW-1:0]    sel6;
    logic [BW-1:0]    o_b6;
    logic             o_valid6;
    logic             ready6;
    logic [SW-1:0]    o_src6;

    mux_n_to_1_stream #(.BIT_WIDTH(BW), .NUM_INPUTS(N), .SEL_WIDTH(SW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_A(a), .i_valid(valid), .o_ready(o_ready),
        .i_mode(mode), .i_sel(sel), .o_B(o_b), .o_valid(o_valid), .i_ready(ready), .o_src(o_src)
    );

    mux_n_to_1_stream #(.BIT_WIDTH(BW), .NUM_INPUTS(N6), .SEL_WIDTH(SW)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_A(a6), .i_valid(valid6), .o_ready(o_ready6),
        .i_mode(mode6), .i_sel(sel6), .o_B(o_b6), .o_valid(o_valid6), .i_ready(ready6), .o_src(o_src6)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [BW-1:0] data;
        logic [SW-1:0] src;
    } word_t;

    word_t sb_q[$];
    bit    m_valid = 1'b0;
    int    m_ptr   = N - 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration written straight from the channel-selection rules.
    function automatic void model_grant(output bit g, output int idx);
        g   = 1'b0;
        idx = 0;
        if (m_valid && !ready) return;
        if (RR_ON && mode) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (valid[c]) begin
                    g   = 1'b1;
                    idx = c;
                    return;
                end
            end
        end else if (int'(sel) < N && valid[sel]) begin
            g   = 1'b1;
            idx = int'(sel);
        end
    endfunction

    // Model: predicts o_ready and pushes each accepted word into the scoreboard.
    always @(negedge clk) begin
        bit            g;
        int            idx;
        logic [N-1:0]  exp_ready;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr   = N - 1;
            sb_q.delete();
            check("reset_o_ready", o_ready, 0);
            check("reset_o_valid", o_valid, 0);
        end else begin
            check("o_valid", o_valid, m_valid);
            model_grant(g, idx);
            exp_ready = '0;
            if (g) exp_ready[idx] = 1'b1;
            check("o_ready", o_ready, exp_ready);
            if (g) begin
                sb_q.push_back('{a[idx*BW +: BW], SW'(idx)});
                m_valid = 1'b1;
                if (RR_ON && mode) m_ptr = idx;
            end else if (ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: every word the downstream consumes must match the scoreboard head.
    always @(negedge clk) begin
        word_t w;
        if (rst_n && o_valid && ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got src %0d data %0h expected no word", o_src, o_b);
            end else begin
                w = sb_q.pop_front();
                $display("word: src=%0d data=%04h", o_src, o_b);
                check("o_B", o_b, w.data);
                check("o_src", o_src, w.src);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int ch, input logic [BW-1:0] d);
        a[ch*BW +: BW] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; valid = '0; mode = 1'b0; sel = '0; ready = 1'b0;
        a6 = '0; valid6 = '0; mode6 = 1'b0; sel6 = '0; ready6 = 1'b0;
        #2;
        check("init_o_valid", o_valid, 0);
        check("init_o_B", o_b, 0);
        check("init_o_src", o_src, 0);
        check("init_o_ready", o_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed select of channel 3
        for (int c = 0; c < N; c++) set_chan(c, 16'(c * 16'h0111 + 16'h1000));
        set_chan(3, 16'h00A3);
        valid = 8'hFF; sel = 3'd3; mode = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("fixed_sel3_ready", o_ready, 8'h08);
        tick();
        valid = '0;
        check("fixed_sel3_B", o_b, 16'h00A3);
        check("fixed_sel3_src", o_src, 3);
        check("fixed_sel3_valid", o_valid, 1);
        tick();

        // Six-input instance: out-of-range select grants nothing
        for (int c = 0; c < N6; c++) a6[c*BW +: BW] = 16'($urandom);
        a6[5*BW +: BW] = 16'h5A5A;
        sel6 = 3'd7; valid6 = 6'h3F; ready6 = 1'b1; mode6 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("n6_sel7_ready", o_ready6, 0);
            check("n6_sel7_valid", o_valid6, 0);
        end
        tick();
        sel6 = 3'd5;
        @(negedge clk);
        check("n6_sel5_ready", o_ready6, 6'h20);
        tick();
        valid6 = '0;
        check("n6_sel5_valid", o_valid6, 1);
        check("n6_sel5_B", o_b6, 16'h5A5A);
        check("n6_sel5_src", o_src6, 5);

        // Backpressure: the held word must survive five stalled cycles
        set_chan(2, 16'h1234);
        sel = 3'd2; valid = 8'hFF; ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_chan(2, 16'($urandom));
            @(negedge clk);
            check("stall_o_ready", o_ready, 0);
            check("stall_o_B", o_b, 16'h1234);
            tick();
        end
        ready = 1'b1;
        tick();
        check("stall_release_valid", o_valid, 1);
        check("stall_release_B", o_b, a[2*BW +: BW]);
        valid = '0;
        tick();

`ifdef MUX_STREAM_RR_EN
        // Round-robin from the reset pointer: 0..7 then 0,1 with no gap
        mode = 1'b1; valid = 8'hFF; ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rr_seq_src", o_src, k % N);
            check("rr_seq_valid", o_valid, 1);
        end
        valid = 8'h80;
        tick();
        check("rr_to7_src", o_src, 7);
        valid = 8'b1000_0010;
        tick();
        check("rr_wrap1_src", o_src, 1);
        tick();
        check("rr_wrap7_src", o_src, 7);
        tick();
        check("rr_wrap1b_src", o_src, 1);
        valid = '0;
        tick();
`endif

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) set_chan(c, 16'($urandom));
            valid = N'($urandom);
            sel   = SW'($urandom_range(0, N - 1));
            mode  = 1'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset in the middle of a held word
        valid = 8'hFF; sel = 3'd4; mode = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("pre_reset_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", o_valid, 0);
        check("async_reset_B", o_b, 0);
        check("async_reset_src", o_src, 0);
        check("async_reset_ready", o_ready, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        sel = 3'd5; mode = 1'b1; valid = 8'hFF; ready = 1'b1;
        tick();
        check("post_reset_src", o_src, RR_ON ? 0 : 5);
        check("post_reset_valid", o_valid, 1);

        // Drain and confirm every accepted word was delivered
        valid = '0; ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
